mul8_seq_ctrl: RTL and testbench
================================

MUL8_SEQ_CTRL -- requirements
Module: mul8_seq_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 2, giving the width of the opaque tag carried from request to result.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, controller can accept a request.
REQ-006 SHALL have port x, input, 8, multiplicand.
REQ-007 SHALL have port y, input, 8, multiplier.
REQ-008 SHALL have port in_tag, input, TAG_W, request tag.
REQ-009 SHALL have port abort, input, 1, synchronous cancel of an in-flight multiply.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port o, output, 16, unsigned product x*y.
REQ-013 SHALL have port out_tag, output, TAG_W, tag of the request that produced o.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL compute the 16-bit unsigned product by sequencing one shared 4x4 unsigned multiplier core over four nibble partial products.
REQ-016 SHALL implement the states IDLE, MUL and DONE.
REQ-017 SHALL drive in_ready=1 in IDLE, in_ready=out_ready in DONE, and in_ready=0 in MUL.
REQ-018 SHALL, on an accept edge (in_valid&in_ready), capture x, y and in_tag, clear the accumulator and step counter k to 0, and enter MUL.
REQ-019 SHALL, in MUL step k (0..3), feed the core x nibble k[0] and y nibble k[1], and add the 8-bit core result shifted left by 4*(k[0]+k[1]) into a 16-bit accumulator.
REQ-020 SHALL need no carry-out on the accumulator, because the maximum product 0xFE01 fits in 16 bits.
REQ-021 SHALL leave MUL for DONE on the edge performing step 3, so out_valid rises exactly 4 edges after the accept edge.
REQ-022 SHALL drive o and out_tag from registers that hold stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, in DONE on out_ready=1 with no new request, return to IDLE with out_valid=0.
REQ-024 SHALL, in DONE on simultaneous out_ready=1 and in_valid=1, complete the result handshake and accept the new request on the same edge, entering MUL with no bubble.
REQ-025 SHALL, on abort=1 in MUL, go to IDLE, discard the operation, and produce no out_valid.
REQ-026 SHALL ignore abort in IDLE and DONE, so a completed result is never cancelled.
REQ-027 SHALL ignore x, y and in_tag changes while not accepting.
REQ-028 SHALL ignore in_valid when in_ready=0.

Reset
REQ-029 SHALL, on rst_n=0 and regardless of clk, force state IDLE, k=0, accumulator 0, o=0, out_tag=0, out_valid=0 and busy=0.
REQ-030 SHALL, when reset is asserted mid-MUL or in DONE, lose the operation and emit no result after reset release.
REQ-031 SHALL assert in_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-032 SHALL place the state enumeration (IDLE/MUL/DONE) and the constants NIB_W=4 and NSTEP=4 in a shared package mul_ctrl_pkg.
REQ-033 SHALL instantiate exactly one sub-module, mul4_core: a combinational unsigned 4x4->8 multiplier built from AND partial products, half/full-adder compression and a prefix final adder.
REQ-034 SHALL contain no other arithmetic multiplier.

Verification
REQ-035 SHALL cover: accept x=0xFF, y=0xFF, in_tag=2 at edge T -> out_valid high after edge T+4 with o=0xFE01 and out_tag=2.
REQ-036 SHALL cover: x=0x00, y=0xA5 -> o=0x0000; then x=0x12, y=0x34 -> o=0x03A8.
REQ-037 SHALL cover: out_ready held 0 for 10 cycles after a result -> o, out_tag and out_valid stable and in_ready=0, then out_ready=1 completes the handshake.
REQ-038 SHALL cover: back-to-back requests with out_ready=1 and in_valid=1 in DONE (0x0F*0x10 then 0x80*0x02) -> results 0x00F0 then 0x0100, one result every 5 cycles.
REQ-039 SHALL cover: abort at step 2 -> no out_valid, return to IDLE; the next request 0x03*0x05 -> o=0x000F.
REQ-040 SHALL cover: rst_n pulsed low mid-MUL, between clock edges -> all outputs 0 immediately, in_ready=1 after release, and no stale result.
REQ-041 SHALL cover: a randomised run of 1000 operands checked against a reference product model.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - shared constants and state encoding for the sequential 8x8 multiplier
package mul_ctrl_pkg;

    localparam int NIB_W = 4;
    localparam int NSTEP = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] LAST_K = 2'(NSTEP - 1);

endpackage

// File: rtl/mul4_core.sv
// rtl/mul4_core.sv - combinational unsigned 4x4->8 multiplier: AND rows, carry-save compression, Kogge-Stone adder
module mul4_core
    import mul_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0]   a_i,
    input  logic [NIB_W-1:0]   b_i,
    output logic [2*NIB_W-1:0] p_o
);

    localparam int PW = 2 * NIB_W;

    function automatic logic [PW-1:0] pp_row(input logic [NIB_W-1:0] a, input logic b_bit, input int sh);
        logic [PW-1:0] r;
        r = {{NIB_W{1'b0}}, a & {NIB_W{b_bit}}};
        return r << sh;
    endfunction

    function automatic logic [PW-1:0] ks_g(input logic [PW-1:0] g, input logic [PW-1:0] p, input int d);
        logic [PW-1:0] r;
        for (int i = 0; i < PW; i++) begin
            if (i >= d) r[i] = g[i] | (p[i] & g[i-d]);
            else        r[i] = g[i];
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] ks_p(input logic [PW-1:0] p, input int d);
        logic [PW-1:0] r;
        for (int i = 0; i < PW; i++) begin
            if (i >= d) r[i] = p[i] & p[i-d];
            else        r[i] = p[i];
        end
        return r;
    endfunction

    logic [PW-1:0] r0, r1, r2, r3;
    logic [PW-1:0] s1, c1, s2, c2;
    logic [PW-1:0] g0, p0, g1, p1, g2, p2, g3;

    assign r0 = pp_row(a_i, b_i[0], 0);
    assign r1 = pp_row(a_i, b_i[1], 1);
    assign r2 = pp_row(a_i, b_i[2], 2);
    assign r3 = pp_row(a_i, b_i[3], 3);

    // Two 3:2 full-adder layers; dropped top carries are harmless since the product is below 2**PW
    assign s1 = r0 ^ r1 ^ r2;
    assign c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    assign s2 = s1 ^ c1 ^ r3;
    assign c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;

    assign g0 = s2 & c2;
    assign p0 = s2 ^ c2;
    assign g1 = ks_g(g0, p0, 1);
    assign p1 = ks_p(p0, 1);
    assign g2 = ks_g(g1, p1, 2);
    assign p2 = ks_p(p1, 2);
    assign g3 = ks_g(g2, p2, 4);

    assign p_o = p0 ^ {g3[PW-2:0], 1'b0};

endmodule

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 unsigned multiplier sequencing one 4x4 core over four nibble steps
module mul8_seq_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      o,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [15:0]      acc_q, acc_d;
    logic [7:0]       x_q, x_d, y_q, y_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      o_q, o_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic [NIB_W-1:0]   core_a, core_b;
    logic [2*NIB_W-1:0] core_p;
    logic [3:0]         shamt;
    logic [15:0]        acc_sum;
    logic               accept;

    // k[0] selects the x nibble, k[1] the y nibble; weight is 4*(k[0]+k[1])
    assign core_a  = k_q[0] ? x_q[7:4] : x_q[3:0];
    assign core_b  = k_q[1] ? y_q[7:4] : y_q[3:0];
    assign shamt   = {k_q[0] & k_q[1], k_q[0] ^ k_q[1], 2'b00};
    assign acc_sum = acc_q + ({8'b0, core_p} << shamt);

    mul4_core u_core (
        .a_i (core_a),
        .b_i (core_b),
        .p_o (core_p)
    );

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign o         = o_q;
    assign out_tag   = out_tag_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        x_d       = x_q;
        y_d       = y_q;
        tag_d     = tag_q;
        o_d       = o_q;
        out_tag_d = out_tag_q;
        case (state_q)
            ST_IDLE: ;
            ST_MUL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_sum;
                    k_d   = k_q + 2'd1;
                    if (k_q == LAST_K) begin
                        state_d   = ST_DONE;
                        o_d       = acc_sum;
                        out_tag_d = tag_q;
                    end
                end
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Accept overrides DONE->IDLE so a result handshake and a new request share one edge
        if (accept) begin
            state_d = ST_MUL;
            k_d     = 2'd0;
            acc_d   = 16'd0;
            x_d     = x;
            y_d     = y;
            tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            k_q       <= 2'd0;
            acc_q     <= 16'd0;
            x_q       <= 8'd0;
            y_q       <= 8'd0;
            tag_q     <= '0;
            o_q       <= 16'd0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            y_q       <= y_d;
            tag_q     <= tag_d;
            o_q       <= o_d;
            out_tag_q <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - self-checking bench for mul8_seq_ctrl
module tb_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  x = 8'd0;
    logic [7:0]  y = 8'd0;
    logic [1:0]  in_tag = 2'd0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] o;
    logic [1:0]  out_tag;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    mul8_seq_ctrl #(.TAG_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .in_tag    (in_tag),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [1:0] t);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x = a;
        y = b;
        in_tag = t;
        tick();
        in_valid = 1'b0;
        x = 8'($urandom);
        y = 8'($urandom);
        in_tag = 2'($urandom);
    endtask

    // Reference: result is the plain arithmetic product, valid 4 edges after the accept edge
    task automatic wait_result(input logic [7:0] a, input logic [7:0] b, input logic [1:0] t);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            in_valid = (n < 3) ? 1'($urandom) : 1'b0;
            x = 8'($urandom);
            y = 8'($urandom);
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'd4);
        chk("product", 32'(o), 32'(a) * 32'(b));
        chk("out_tag", 32'(out_tag), 32'(t));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [1:0] rt;
        int seen;

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_o", 32'(o), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        accept(8'hFF, 8'hFF, 2'd2);
        wait_result(8'hFF, 8'hFF, 2'd2);
        chk("max_product_const", 32'(o), 32'hFE01);
        release_result();
        accept(8'h00, 8'hA5, 2'd1);
        wait_result(8'h00, 8'hA5, 2'd1);
        release_result();
        accept(8'h12, 8'h34, 2'd3);
        wait_result(8'h12, 8'h34, 2'd3);
        chk("product_0x12_0x34", 32'(o), 32'h03A8);
        release_result();

        // Backpressure: result held, requests and abort ignored while in DONE
        accept(8'h5A, 8'hC3, 2'd1);
        wait_result(8'h5A, 8'hC3, 2'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            x = 8'($urandom);
            abort = 1'($urandom);
            tick();
            chk("hold_o", 32'(o), 32'h5A * 32'hC3);
            chk("hold_out_tag", 32'(out_tag), 32'd1);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        abort = 1'b0;
        release_result();

        // Back-to-back: handshake and new accept on one edge
        accept(8'h0F, 8'h10, 2'd0);
        wait_result(8'h0F, 8'h10, 2'd0);
        chk("b2b_first", 32'(o), 32'h00F0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        x = 8'h80;
        y = 8'h02;
        in_tag = 2'd1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("b2b_gap_out_valid", 32'(out_valid), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd1);
        wait_result(8'h80, 8'h02, 2'd1);
        chk("b2b_second", 32'(o), 32'h0100);
        release_result();

        // Abort while step 2 is pending
        accept(8'h77, 8'h99, 2'd2);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (6) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        accept(8'h03, 8'h05, 2'd1);
        wait_result(8'h03, 8'h05, 2'd1);
        chk("after_abort", 32'(o), 32'h000F);
        release_result();

        // Asynchronous reset mid-MUL, asserted and released between edges
        accept(8'hAB, 8'hCD, 2'd3);
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_o", 32'(o), 32'd0);
        chk("arst_out_tag", 32'(out_tag), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("arst_no_stale", 32'(seen), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rt = 2'($urandom);
            accept(ra, rb, rt);
            wait_result(ra, rb, rt);
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("rand_stall_o", 32'(o), 32'(ra) * 32'(rb));
            end
            release_result();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
